// File: rtl/memory_burst.sv
// memory_burst: big-endian byte memory serving 1/4/8/16-word bursts.
// Optional address checking: define MEMORY_BOUNDS_CHECK_EN.
module memory_burst #(
  parameter int unsigned DEPTH_BYTES = 1048576,
  parameter logic [31:0] BASE_ADDR   = 32'h8002_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        rw,
  input  logic [31:0] address,
  input  logic [1:0]  access_size,
  input  logic [31:0] data_in,
  output logic        busy,
  output logic [31:0] data_out,
  output logic        data_valid,
  output logic        error
);

  localparam int unsigned AW = $clog2(DEPTH_BYTES);
  localparam int unsigned WW = AW - 2;

  typedef enum logic [1:0] {
    IDLE,
    RBURST,
    WBURST
  } state_t;

  state_t        state_q, state_d;
  logic [4:0]    remaining_q, remaining_d;
  logic [WW-1:0] ptr_q, ptr_d;
  logic [31:0]   data_out_q, data_out_d;
  logic          data_valid_q, data_valid_d;
  logic          error_q, error_d;

  logic [7:0]    mem [DEPTH_BYTES];

  logic [31:0]   diff;
  logic [WW-1:0] start_w;
  logic [WW-1:0] beat_w;
  logic [31:0]   rd_word;
  logic [4:0]    beats;
  logic          reject;
  logic          wr_en;
  logic          unused_bits;

  // Offset inside the window; the word index wraps naturally.
  assign diff        = address - BASE_ADDR;
  assign start_w     = diff[AW-1:2];
  assign unused_bits = ^{diff[31:AW], diff[1:0]};

  // Idle beats use the incoming address, burst beats the pointer.
  assign beat_w = (state_q == IDLE) ? start_w : ptr_q;

  assign rd_word = {mem[{beat_w, 2'd0}],
                    mem[{beat_w, 2'd1}],
                    mem[{beat_w, 2'd2}],
                    mem[{beat_w, 2'd3}]};

  // Burst length decode.
  always_comb begin
    beats = 5'd1;
    unique case (access_size)
      2'b00:   beats = 5'd1;
      2'b01:   beats = 5'd4;
      2'b10:   beats = 5'd8;
      default: beats = 5'd16;
    endcase
  end

`ifdef MEMORY_BOUNDS_CHECK_EN
  logic [32:0] last_byte;
  logic [32:0] limit;

  assign last_byte = {1'b0, address}
                   + {26'd0, beats, 2'b00}
                   - 33'd1;
  assign limit     = {1'b0, BASE_ADDR}
                   + 33'(DEPTH_BYTES)
                   - 33'd1;
  assign reject    = (address[1:0] != 2'b00)
                  || (address < BASE_ADDR)
                  || (last_byte > limit);
`else
  assign reject = 1'b0;
`endif

  // Next state, beat control and registered read data.
  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    ptr_d        = ptr_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    error_d      = 1'b0;
    wr_en        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          if (reject) begin
            error_d = 1'b1;
          end else begin
            ptr_d       = beat_w + WW'(1);
            remaining_d = beats - 5'd1;
            if (rw) begin
              wr_en = 1'b1;
            end else begin
              data_out_d   = rd_word;
              data_valid_d = 1'b1;
            end
            if (beats != 5'd1) begin
              state_d = rw ? WBURST : RBURST;
            end
          end
        end
      end
      RBURST: begin
        data_out_d   = rd_word;
        data_valid_d = 1'b1;
        ptr_d        = ptr_q + WW'(1);
        remaining_d  = remaining_q - 5'd1;
        if (remaining_q == 5'd1) begin
          state_d = IDLE;
        end
      end
      WBURST: begin
        wr_en       = 1'b1;
        ptr_d       = ptr_q + WW'(1);
        remaining_d = remaining_q - 5'd1;
        if (remaining_q == 5'd1) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      remaining_q  <= 5'd0;
      ptr_q        <= '0;
      data_out_q   <= 32'd0;
      data_valid_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      ptr_q        <= ptr_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      error_q      <= error_d;
    end
  end

  // Storage is untouched by reset; a reset edge blocks the beat.
  always_ff @(posedge clock) begin
    if (reset_n && wr_en) begin
      mem[{beat_w, 2'd0}] <= data_in[31:24];
      mem[{beat_w, 2'd1}] <= data_in[23:16];
      mem[{beat_w, 2'd2}] <= data_in[15:8];
      mem[{beat_w, 2'd3}] <= data_in[7:0];
    end
  end

  assign busy       = (state_q != IDLE);
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign error      = error_q;

endmodule

// File: tb/tb_memory_burst.sv
// tb_memory_burst: directed checks for memory_burst.
// Boundary case follows MEMORY_BOUNDS_CHECK_EN.
module tb_memory_burst;

  localparam logic [31:0] BASE  = 32'h8002_0000;
  localparam int unsigned DEPTH = 1048576;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        rw;
  logic [31:0] address;
  logic [1:0]  access_size;
  logic [31:0] data_in;
  logic        busy;
  logic [31:0] data_out;
  logic        data_valid;
  logic        error;

  int n_checks = 0;
  int n_fail   = 0;
  int bcnt;

  memory_burst #(
    .DEPTH_BYTES(DEPTH),
    .BASE_ADDR  (BASE)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .rw         (rw),
    .address    (address),
    .access_size(access_size),
    .data_in    (data_in),
    .busy       (busy),
    .data_out   (data_out),
    .data_valid (data_valid),
    .error      (error)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic cmd(input logic w,
                     input logic [31:0] a,
                     input logic [1:0] sz,
                     input logic [31:0] d);
    enable      = 1'b1;
    rw          = w;
    address     = a;
    access_size = sz;
    data_in     = d;
  endtask

  task automatic put_word(input logic [19:0] o,
                          input logic [31:0] w);
    dut.mem[o]         = w[31:24];
    dut.mem[o + 20'd1] = w[23:16];
    dut.mem[o + 20'd2] = w[15:8];
    dut.mem[o + 20'd3] = w[7:0];
  endtask

  function automatic logic [31:0] get_word(
    input logic [19:0] o);
    return {dut.mem[o], dut.mem[o + 20'd1],
            dut.mem[o + 20'd2], dut.mem[o + 20'd3]};
  endfunction

  initial begin
    logic [31:0] exp4 [4];
    logic [19:0] o;

    reset_n     = 1'b0;
    enable      = 1'b0;
    rw          = 1'b0;
    address     = 32'd0;
    access_size = 2'b00;
    data_in     = 32'd0;

    put_word(20'h00004, 32'h4444_4444);
    put_word(20'h00008, 32'h8888_8888);
    put_word(20'h0000C, 32'hCCCC_CCCC);
    put_word(20'hFFFF8, 32'hE0E0_0008);
    put_word(20'hFFFFC, 32'hE0E0_0004);
    for (int k = 0; k < 8; k++) begin
      o = 20'h100 + 20'(k * 4);
      put_word(o, 32'hCAFE_0000 + 32'(k));
    end

    tick;
    tick;
    check("rst_busy", busy, 0);
    check("rst_dv", data_valid, 0);
    check("rst_dout", data_out, 0);
    check("rst_err", error, 0);
    reset_n = 1'b1;
    tick;

    cmd(1'b1, BASE, 2'b00, 32'hDEAD_BEEF);
    tick;
    enable = 1'b0;
    check("w1_busy", busy, 0);
    check("w1_dv", data_valid, 0);
    check("w1_byte0", dut.mem[0], 32'hDE);
    cmd(1'b0, BASE, 2'b00, 32'd0);
    tick;
    enable = 1'b0;
    check("r1_dv", data_valid, 1);
    check("r1_data", data_out, 32'hDEAD_BEEF);
    check("r1_busy", busy, 0);
    tick;
    check("r1_dv_drop", data_valid, 0);
    check("r1_hold", data_out, 32'hDEAD_BEEF);

    cmd(1'b1, BASE + 32'h40, 2'b11, 32'h1000);
    tick;
    enable = 1'b0;
    bcnt = 0;
    for (int k = 1; k < 16; k++) begin
      if (busy) bcnt++;
      data_in = 32'h1000 + 32'(k);
      tick;
    end
    check("w16_busy_cnt", bcnt, 15);
    check("w16_busy_end", busy, 0);
    check("w16_word15", get_word(20'h7C), 32'h100F);

    cmd(1'b0, BASE + 32'h40, 2'b11, 32'd0);
    tick;
    enable = 1'b0;
    bcnt = 0;
    for (int k = 0; k < 16; k++) begin
      check("r16_dv", data_valid, 1);
      check("r16_data", data_out, 32'h1000 + 32'(k));
      if (busy) bcnt++;
      if (k == 15) cmd(1'b0, BASE, 2'b00, 32'd0);
      tick;
    end
    enable = 1'b0;
    check("r16_busy_cnt", bcnt, 15);
    check("b2b_dv", data_valid, 1);
    check("b2b_data", data_out, 32'hDEAD_BEEF);
    tick;
    check("b2b_dv_drop", data_valid, 0);

    cmd(1'b0, BASE + 32'h40, 2'b01, 32'd0);
    tick;
    for (int j = 0; j < 4; j++) begin
      if (j < 3) cmd(1'b1, BASE, 2'b00, 32'h1234_5678);
      else enable = 1'b0;
      check("mid_data", data_out, 32'h1000 + 32'(j));
      tick;
    end
    enable = 1'b0;
    check("mid_mem", get_word(20'h0), 32'hDEAD_BEEF);
    check("mid_busy", busy, 0);

    cmd(1'b1, BASE + 32'h100, 2'b10, 32'hB000_0000);
    tick;
    enable  = 1'b0;
    data_in = 32'hB000_0001;
    tick;
    reset_n = 1'b0;
    data_in = 32'hB000_0002;
    tick;
    check("abort_busy", busy, 0);
    check("abort_dv", data_valid, 0);
    reset_n = 1'b1;
    data_in = 32'hB000_0003;
    tick;
    tick;
    check("abort_busy2", busy, 0);
    for (int k = 0; k < 8; k++) begin
      o = 20'h100 + 20'(k * 4);
      check("abort_word", get_word(o),
            (k < 2) ? 32'hB000_0000 + 32'(k)
                    : 32'hCAFE_0000 + 32'(k));
    end

`ifdef MEMORY_BOUNDS_CHECK_EN
    cmd(1'b0, BASE + 32'h2, 2'b01, 32'd0);
    tick;
    enable = 1'b0;
    check("mis_err", error, 1);
    check("mis_dv", data_valid, 0);
    check("mis_busy", busy, 0);
    tick;
    check("mis_err_drop", error, 0);
    check("mis_dv2", data_valid, 0);
    cmd(1'b0, BASE + DEPTH - 8, 2'b01, 32'd0);
    tick;
    enable = 1'b0;
    check("oob_err", error, 1);
    check("oob_dv", data_valid, 0);
    check("oob_busy", busy, 0);
    tick;
    check("oob_err_drop", error, 0);
    check("oob_dv2", data_valid, 0);
`else
    exp4[0] = 32'hDEAD_BEEF;
    exp4[1] = 32'h4444_4444;
    exp4[2] = 32'h8888_8888;
    exp4[3] = 32'hCCCC_CCCC;
    cmd(1'b0, BASE + 32'h2, 2'b01, 32'd0);
    tick;
    enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("mis_dv", data_valid, 1);
      check("mis_err", error, 0);
      check("mis_data", data_out, exp4[k]);
      tick;
    end
    exp4[0] = 32'hE0E0_0008;
    exp4[1] = 32'hE0E0_0004;
    exp4[2] = 32'hDEAD_BEEF;
    exp4[3] = 32'h4444_4444;
    cmd(1'b0, BASE + DEPTH - 8, 2'b01, 32'd0);
    tick;
    enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("wrap_dv", data_valid, 1);
      check("wrap_err", error, 0);
      check("wrap_data", data_out, exp4[k]);
      tick;
    end
    check("wrap_dv_drop", data_valid, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_burst.md
# memory_burst

Parametrised byte-addressed, big-endian instruction/data memory for the MIPS processor, serving single-word and 4/8/16-word bursts over a 32-bit bus. A busy handshake controls it: one command per idle cycle, with reads streamed one word per cycle. It sits between the fetch/memory stages and the program image loaded by the testbench. Optional address checking flags misaligned or out-of-window accesses.

## Interface
- DEPTH_BYTES, 1048576: memory size in bytes; power of two, multiple of 64.
- BASE_ADDR, 32'h8002_0000: byte address that maps to array offset 0.
- clock  input  1  rising-edge clock.
- reset_n  input  1  synchronous, active-low reset (sampled on rising clock edge).
- enable  input  1  command request; sampled only while busy=0.
- rw  input  1  1 = write, 0 = read.
- address  input  32  start byte address of the burst.
- access_size  input  2  00 = 1 word, 01 = 4 words, 10 = 8 words, 11 = 16 words.
- data_in  input  32  write data; one word per beat.
- busy  output  1  burst in progress; new commands are ignored.
- data_out  output  32  read data, registered.
- data_valid  output  1  data_out carries a read beat this cycle.
- error  output  1  one-cycle pulse: command rejected (only with checking compiled in).

## Operation
- Storage is a byte array of DEPTH_BYTES entries. A word at offset o is {mem[o], mem[o+1], mem[o+2], mem[o+3]} (big-endian).
- offset = (address - BASE_ADDR) mod DEPTH_BYTES, with bits [1:0] forced to 0. Beat k uses offset + 4k, wrapping modulo DEPTH_BYTES.
- N = 1/4/8/16 from access_size. The counter is 5 bits and holds the beats remaining.
- States:
  - IDLE: busy=0. On an edge with enable=1 and no rejection, the command is accepted. Beat 0 executes at that same edge, and the block moves to RBURST/WBURST with remaining = N-1 if N>1, else stays in IDLE.
  - RBURST: each edge outputs the next word and decrements remaining. At remaining 1→0 the block returns to IDLE.
  - WBURST: each edge writes data_in to the next word and decrements remaining. At remaining 1→0 the block returns to IDLE.
- busy = (state != IDLE). busy is low during the cycle carrying the last beat, so a new command can be accepted on the edge that ends it.
- enable, rw, address, access_size are ignored while busy=1. Address and size are latched at acceptance.
- data_out holds its last value when data_valid=0. Writes never assert data_valid.
- Memory contents are not affected by reset. Initial contents are X or loaded by the bench through hierarchical access.

## Timing
- Reset (reset_n=0 at an edge): state IDLE, busy=0, data_valid=0, data_out=0, error=0, counter=0.
- Reset during a burst aborts it. Beats already written persist, no further beats execute, and data_valid drops on the next cycle.
- Read latency is 1: beat k is on data_out with data_valid=1 in the cycle following edge E0+k.
- For an N-word read, data_valid is high for exactly N consecutive cycles and busy for N-1 cycles.
- Write beat k samples data_in at edge E0+k. Writes take effect at that edge.
- Write then read: a read accepted on the edge after the last write beat returns the new data.
- A read of a location written by the same edge returns the old data.
- Rejection: error=1 for the single cycle after the edge. busy, data_valid and memory are unchanged.

## Configuration
- MEMORY_BOUNDS_CHECK_EN defined: on an edge with enable=1 and busy=0, the command is rejected if any of the following holds:
  - address[1:0] != 0;
  - address < BASE_ADDR;
  - address + 4N - 1 > BASE_ADDR + DEPTH_BYTES - 1.

  Rejected commands execute no beats and pulse error. Wrap-around therefore never occurs.
- Not defined: error is tied to 0. Low address bits are ignored and offsets wrap as described in Operation.

## Test plan
- Reset with reset_n=0 for 2 cycles: busy=0, data_valid=0, data_out=0, error=0.
- Single write then read: write 32'hDEADBEEF to 0x8002_0000, then read it. Expect data_out=32'hDEADBEEF one cycle after the read is accepted, data_valid high for 1 cycle, busy never high. The byte at offset 0 is 8'hDE.
- 16-word burst: write 16 words 0x1000+k at 0x8002_0040, then a 16-word read. Expect busy high 15 cycles and data_valid high 16 consecutive cycles with data 0x1000..0x100F. A second read accepted on the last-beat cycle returns its beat 0 without a gap.
- enable asserted mid-burst with rw=1 during a 4-word read: the command is ignored and memory is unchanged.
- reset_n=0 at beat 2 of an 8-word write: words 0-1 are written, words 2-7 keep their old values, busy=0 the next cycle.
- Boundary checking:
  - With MEMORY_BOUNDS_CHECK_EN: a 4-word read at 0x8002_0002 and a 4-word read at BASE+DEPTH-8 each give error=1 for one cycle, with no data_valid.
  - Without it: the second read wraps, returning offsets DEPTH-8, DEPTH-4, 0, 4.
